// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter:
// FSM state encoding and the digit range/correction constants.
package bcd2bin_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam logic [3:0] ADJ_THRESH = 4'd8;
   localparam logic [3:0] ADJ_VAL    = 4'd3;

   function automatic logic digit_illegal(input logic [3:0] digit);
      return digit > BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready handshake bundle between a BCD producer, the converter and the
// result consumer. The master side drives requests and accepts results.
interface bcd2bin_seq_if #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
);

   logic                  in_valid;
   logic                  in_ready;
   logic [4*DIGITS-1:0]   bcd_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [BIN_W-1:0]      bin_out;
   logic                  err;

   modport master (
      output in_valid, bcd_in, out_ready,
      input  in_ready, out_valid, bin_out, err
   );

   modport slave (
      input  in_valid, bcd_in, out_ready,
      output in_ready, out_valid, bin_out, err
   );

endinterface

// File: rtl/bcd2bin_seq_bcd_digit_adj.sv
// Reverse double-dabble correction for one BCD digit: after a right shift a
// digit of 8 or more absorbed a half-ten from its neighbour and loses 3.
module bcd_digit_adj
   import bcd2bin_seq_pkg::*;
(
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   assign adjusted = (digit >= ADJ_THRESH) ? (digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one right shift plus per-digit -3
// correction per clock, BIN_W shifts per conversion, valid/ready on both sides.
module bcd2bin_seq
   import bcd2bin_seq_pkg::*;
#(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input logic           clk,
   input logic           rst_n,
   bcd2bin_seq_if.slave  bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SR_W  = BCD_W + BIN_W;
   localparam int CNT_W = $clog2(BIN_W + 1);

   state_t             state;
   state_t             state_next;
   logic [SR_W-1:0]    sr;
   logic [SR_W-1:0]    shifted;
   logic [SR_W-1:0]    sr_next;
   logic [BCD_W-1:0]   adj_field;
   logic [CNT_W-1:0]   count;
   logic               bad_digit;
   logic               last_shift;

   assign shifted = sr >> 1;

   // Correction is applied to the post-shift digits within the same cycle.
   for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (shifted[BIN_W + 4*i +: 4]),
         .adjusted (adj_field[4*i +: 4])
      );
   end

   assign sr_next    = {adj_field, shifted[BIN_W-1:0]};
   assign last_shift = (count == CNT_W'(BIN_W - 1));

   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (digit_illegal(bus.bcd_in[4*i +: 4])) begin
            bad_digit = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               state_next = bad_digit ? DONE : CONV;
            end
         end
         CONV: begin
            if (last_shift) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Result registers change only on entry to DONE so they stay stable there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr          <= '0;
         count       <= '0;
         bus.bin_out <= '0;
         bus.err     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sr    <= {bus.bcd_in, {BIN_W{1'b0}}};
                  count <= '0;
                  if (bad_digit) begin
                     bus.bin_out <= '0;
                     bus.err     <= 1'b1;
                  end
               end
            end
            CONV: begin
               sr    <= sr_next;
               count <= count + 1'b1;
               if (last_shift) begin
                  bus.bin_out <= sr_next[BIN_W-1:0];
                  bus.err     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
